pwm_cfg_arbiter: RTL and testbench

Owns the PWM configuration register bank and arbitrates writes into it from two requesters: the SPI write port, which cannot be stalled, and a local on-chip requester using a req/gnt handshake. It sits between the SPI peripheral's decoded write strobe and the PWM datapath, driving the five config outputs. It enforces per-register write locks set over SPI and, when compiled in, ramps the duty cycle toward its target instead of jumping.

---
 rtl/pwm_cfg_arbiter.sv | 147 ++++++++++++++
 tb/tb_pwm_cfg_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_cfg_arbiter.sv
// PWM config register bank: SPI writes (never stalled, fixed priority) and local req/gnt writes with SPI-set locks.
// Define PWM_RAMP_EN to build the duty-cycle ramp engine; otherwise register 0x04 drives the duty directly.
module pwm_cfg_arbiter
`ifdef PWM_RAMP_EN
#(
   parameter int unsigned RAMP_DIV = 16
)
`endif
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       spi_wr_valid,
   input  logic [6:0] spi_wr_addr,
   input  logic [7:0] spi_wr_data,
   input  logic       loc_req,
   input  logic [6:0] loc_addr,
   input  logic [7:0] loc_data,
   output logic       loc_gnt,
   output logic       loc_err,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle,
   output logic [4:0] lock_mask,
   output logic       ramp_busy
);
   localparam logic [6:0] MAX_ADDRESS = 7'h04;
   localparam logic [6:0] LOCK_ADDR   = 7'h07;
   localparam int         NREG        = 5;

   logic [7:0]      cfg_q [0:NREG-1];
   logic [7:0]      cfg_d [0:NREG-1];
   logic [NREG-1:0] lock_mask_q, lock_mask_d;
   logic            loc_gnt_q, loc_gnt_d;
   logic            loc_err_q, loc_err_d;

   logic            loc_accept;
   logic            loc_reject;
   logic            wr_en;
   logic [2:0]      wr_sel;
   logic [7:0]      wr_data;
   logic [7:0]      lock_ext;

   // A request is ignored while its own gnt/err is out, so a held request is never taken twice.
   always_comb begin
      lock_ext    = {3'b000, lock_mask_q};
      loc_accept  = loc_req && !spi_wr_valid && !loc_gnt_q && !loc_err_q;
      loc_reject  = (loc_addr > MAX_ADDRESS) || (loc_addr == LOCK_ADDR) || lock_ext[loc_addr[2:0]];
      wr_en       = 1'b0;
      wr_sel      = spi_wr_addr[2:0];
      wr_data     = spi_wr_data;
      lock_mask_d = lock_mask_q;
      loc_gnt_d   = 1'b0;
      loc_err_d   = 1'b0;
      if (spi_wr_valid) begin
         wr_en = (spi_wr_addr <= MAX_ADDRESS);
         if (spi_wr_addr == LOCK_ADDR) begin
            lock_mask_d = spi_wr_data[NREG-1:0];
         end
      end else if (loc_accept) begin
         wr_sel    = loc_addr[2:0];
         wr_data   = loc_data;
         wr_en     = !loc_reject;
         loc_gnt_d = !loc_reject;
         loc_err_d = loc_reject;
      end
   end

   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         cfg_d[i] = cfg_q[i];
         if (wr_en && (wr_sel == 3'(i))) begin
            cfg_d[i] = wr_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            cfg_q[i] <= 8'h00;
         end
         lock_mask_q <= '0;
         loc_gnt_q   <= 1'b0;
         loc_err_q   <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            cfg_q[i] <= cfg_d[i];
         end
         lock_mask_q <= lock_mask_d;
         loc_gnt_q   <= loc_gnt_d;
         loc_err_q   <= loc_err_d;
      end
   end

`ifdef PWM_RAMP_EN
   // cfg_q[4] is the duty target; duty_q steps toward it once per RAMP_DIV cycles.
   localparam int                CNT_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RAMP_DIV - 1);

   logic             tgt_wr;
   logic [CNT_W-1:0] ramp_cnt_q, ramp_cnt_d;
   logic [7:0]       duty_q, duty_d;

   always_comb begin
      tgt_wr     = wr_en && (wr_sel == 3'd4);
      ramp_cnt_d = ramp_cnt_q + CNT_W'(1);
      duty_d     = duty_q;
      if (tgt_wr) begin
         ramp_cnt_d = '0;
      end else if (ramp_cnt_q == CNT_LAST) begin
         ramp_cnt_d = '0;
         if (duty_q < cfg_q[4]) begin
            duty_d = duty_q + 8'd1;
         end else if (duty_q > cfg_q[4]) begin
            duty_d = duty_q - 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ramp_cnt_q <= '0;
         duty_q     <= 8'h00;
      end else begin
         ramp_cnt_q <= ramp_cnt_d;
         duty_q     <= duty_d;
      end
   end

   assign pwm_duty_cycle = duty_q;
   assign ramp_busy      = (duty_q != cfg_q[4]);
`else
   assign pwm_duty_cycle = cfg_q[4];
   assign ramp_busy      = 1'b0;
`endif

   assign en_reg_out_7_0  = cfg_q[0];
   assign en_reg_out_15_8 = cfg_q[1];
   assign en_reg_pwm_7_0  = cfg_q[2];
   assign en_reg_pwm_15_8 = cfg_q[3];
   assign lock_mask       = lock_mask_q;
   assign loc_gnt         = loc_gnt_q;
   assign loc_err         = loc_err_q;

endmodule

// File: tb/tb_pwm_cfg_arbiter.sv
// Self-checking bench for pwm_cfg_arbiter: directed cases with literal expectations plus a
// randomized run compared every cycle against a register-level model (ramp modelled when PWM_RAMP_EN is set).
module tb_pwm_cfg_arbiter;
`ifdef PWM_RAMP_EN
   localparam int RDIV = 4;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       spi_wr_valid;
   logic [6:0] spi_wr_addr;
   logic [7:0] spi_wr_data;
   logic       loc_req;
   logic [6:0] loc_addr;
   logic [7:0] loc_data;
   logic       loc_gnt, loc_err;
   logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
   logic [7:0] pwm_duty_cycle;
   logic [4:0] lock_mask;
   logic       ramp_busy;

   always #5 clk = ~clk;

`ifdef PWM_RAMP_EN
   pwm_cfg_arbiter #(.RAMP_DIV(RDIV)) dut (
`else
   pwm_cfg_arbiter dut (
`endif
      .clk(clk), .rst_n(rst_n),
      .spi_wr_valid(spi_wr_valid), .spi_wr_addr(spi_wr_addr), .spi_wr_data(spi_wr_data),
      .loc_req(loc_req), .loc_addr(loc_addr), .loc_data(loc_data),
      .loc_gnt(loc_gnt), .loc_err(loc_err),
      .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
      .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
      .pwm_duty_cycle(pwm_duty_cycle), .lock_mask(lock_mask), .ramp_busy(ramp_busy)
   );

   int     checks = 0;
   int     errors = 0;
   longint cyc    = 0;

   // Model state: register contents (index 4 = duty target when ramping), locks, expected pulses.
   logic [7:0] m_reg [0:4];
   logic [4:0] m_lock;
   logic       m_gnt, m_err;
   logic       m_valid = 1'b0;
   logic [7:0] m_start;
   longint     m_t0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, got, exp);
      end
   endtask

`ifdef PWM_RAMP_EN
   // Duty is the segment start value moved one step per RDIV cycles since the target update, clamped at the target.
   function automatic logic [7:0] model_duty(input longint t);
      longint steps, diff;
      steps = (t >= m_t0) ? (t - m_t0) / RDIV : 0;
      diff  = longint'(m_reg[4]) - longint'(m_start);
      if (diff >= 0) return m_start + 8'((diff < steps) ? diff : steps);
      return m_start - 8'(((-diff) < steps) ? -diff : steps);
   endfunction
`endif

   task automatic model_write(input logic [2:0] a, input logic [7:0] d);
`ifdef PWM_RAMP_EN
      if (a == 3'd4) begin
         m_start = model_duty(cyc);
         m_t0    = cyc + 1;
      end
`endif
      m_reg[a] = d;
   endtask

   // Compare process: at each falling edge check the outputs, then advance the model with the inputs the DUT will sample next.
   initial begin
      forever begin
         logic ng, ne;
         @(negedge clk);
         if (m_valid) begin
            chk("en_reg_out_7_0", en_reg_out_7_0, m_reg[0]);
            chk("en_reg_out_15_8", en_reg_out_15_8, m_reg[1]);
            chk("en_reg_pwm_7_0", en_reg_pwm_7_0, m_reg[2]);
            chk("en_reg_pwm_15_8", en_reg_pwm_15_8, m_reg[3]);
            chk("lock_mask", lock_mask, m_lock);
            chk("loc_gnt", loc_gnt, m_gnt);
            chk("loc_err", loc_err, m_err);
`ifdef PWM_RAMP_EN
            chk("pwm_duty_cycle", pwm_duty_cycle, model_duty(cyc));
            chk("ramp_busy", ramp_busy, model_duty(cyc) != m_reg[4]);
`else
            chk("pwm_duty_cycle", pwm_duty_cycle, m_reg[4]);
            chk("ramp_busy", ramp_busy, 1'b0);
`endif
         end
         ng = 1'b0;
         ne = 1'b0;
         if (!rst_n) begin
            for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
            m_lock  = 5'h00;
            m_start = 8'h00;
            m_t0    = cyc + 1;
            m_valid = 1'b1;
         end else begin
            if (spi_wr_valid) begin
               if (spi_wr_addr <= 7'h04) model_write(spi_wr_addr[2:0], spi_wr_data);
               else if (spi_wr_addr == 7'h07) m_lock = spi_wr_data[4:0];
            end else if (loc_req && !m_gnt && !m_err) begin
               if (loc_addr > 7'h04 || loc_addr == 7'h07 || m_lock[loc_addr[2:0]]) begin
                  ne = 1'b1;
               end else begin
                  model_write(loc_addr[2:0], loc_data);
                  ng = 1'b1;
               end
            end
         end
         m_gnt = ng;
         m_err = ne;
         cyc++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic spi_write(input logic [6:0] a, input logic [7:0] d);
      spi_wr_valid = 1'b1;
      spi_wr_addr  = a;
      spi_wr_data  = d;
      tick();
      spi_wr_valid = 1'b0;
      $display("SPI  write addr=0x%02h data=0x%02h", a, d);
   endtask

   task automatic loc_write(input logic [6:0] a, input logic [7:0] d,
                            output logic g, output logic e, output int lat);
      loc_req  = 1'b1;
      loc_addr = a;
      loc_data = d;
      g = 1'b0;
      e = 1'b0;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         lat++;
         if (loc_gnt || loc_err) begin
            g = loc_gnt;
            e = loc_err;
            break;
         end
      end
      loc_req = 1'b0;
      chk("loc_handshake_done", (g || e), 1'b1);
      $display("LOC  write addr=0x%02h data=0x%02h gnt=%0b err=%0b latency=%0d", a, d, g, e, lat);
   endtask

   initial begin
      logic g, e;
      int   lat, r, hold;
      logic req_done;

      rst_n = 1'b0; spi_wr_valid = 1'b0; spi_wr_addr = '0; spi_wr_data = '0;
      loc_req = 1'b0; loc_addr = '0; loc_data = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("reset_out_7_0", en_reg_out_7_0, 8'h00);
      chk("reset_duty", pwm_duty_cycle, 8'h00);
      chk("reset_lock", lock_mask, 5'h00);
      chk("reset_gnt_err", {loc_gnt, loc_err}, 2'b00);
      chk("reset_busy", ramp_busy, 1'b0);

      // Plain SPI write
      spi_write(7'h02, 8'hA5);
      chk("spi_pwm_7_0", en_reg_pwm_7_0, 8'hA5);
      chk("spi_others", {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_15_8}, 24'h0);

      // SPI and local collide on 0x01: SPI lands first, local one cycle later
      spi_wr_valid = 1'b1; spi_wr_addr = 7'h01; spi_wr_data = 8'h11;
      loc_req = 1'b1; loc_addr = 7'h01; loc_data = 8'h3C;
      tick();
      spi_wr_valid = 1'b0;
      chk("collide_spi_first", en_reg_out_15_8, 8'h11);
      chk("collide_no_gnt_yet", {loc_gnt, loc_err}, 2'b00);
      tick();
      chk("collide_local_val", en_reg_out_15_8, 8'h3C);
      chk("collide_gnt", {loc_gnt, loc_err}, 2'b10);
      loc_req = 1'b0;
      tick();
      chk("collide_single_gnt", loc_gnt, 1'b0);
      $display("COLL spi 0x01<-0x11 then local 0x01<-0x3C");

      // Locks and invalid addresses
      spi_write(7'h07, 8'h10);
      chk("lock_set", lock_mask, 5'h10);
      loc_write(7'h04, 8'h80, g, e, lat);
      chk("locked_err", {g, e}, 2'b01);
      chk("locked_latency", lat, 1);
      chk("locked_duty_kept", pwm_duty_cycle, 8'h00);
      loc_write(7'h05, 8'h12, g, e, lat);
      chk("bad_addr_err", {g, e}, 2'b01);
      loc_write(7'h00, 8'h5A, g, e, lat);
      chk("unlocked_gnt", {g, e}, 2'b10);
      spi_write(7'h09, 8'hFF);
      chk("spi_drop_reg0", en_reg_out_7_0, 8'h5A);
      chk("spi_drop_lock", lock_mask, 5'h10);

      // Lock written by SPI in the same cycle applies to the deferred local request
      spi_wr_valid = 1'b1; spi_wr_addr = 7'h07; spi_wr_data = 8'h01;
      loc_req = 1'b1; loc_addr = 7'h00; loc_data = 8'h99;
      tick();
      spi_wr_valid = 1'b0;
      tick();
      chk("same_cycle_lock_err", {loc_gnt, loc_err}, 2'b01);
      chk("same_cycle_lock_val", en_reg_out_7_0, 8'h5A);
      loc_req = 1'b0;
      spi_write(7'h07, 8'h00);

      // Local request blocked by SPI for 5 cycles, held 6 cycles in total
      loc_req = 1'b1; loc_addr = 7'h03; loc_data = 8'hC7;
      spi_wr_valid = 1'b1; spi_wr_addr = 7'h09; spi_wr_data = 8'h00;
      repeat (5) tick();
      chk("blocked_no_update", en_reg_pwm_15_8, 8'h00);
      spi_wr_valid = 1'b0;
      tick();
      chk("blocked_update", en_reg_pwm_15_8, 8'hC7);
      chk("blocked_gnt", loc_gnt, 1'b1);
      loc_req = 1'b0;
      tick();
      chk("blocked_gnt_once", loc_gnt, 1'b0);
      $display("BLK  local 0x03<-0xC7 after 5 SPI cycles");

`ifdef PWM_RAMP_EN
      spi_write(7'h04, 8'h03);
      chk("ramp_t0_duty", pwm_duty_cycle, 8'h00);
      chk("ramp_t0_busy", ramp_busy, 1'b1);
      repeat (3) tick();
      chk("ramp_t3_duty", pwm_duty_cycle, 8'h00);
      tick();
      chk("ramp_t4_duty", pwm_duty_cycle, 8'h01);
      repeat (4) tick();
      chk("ramp_t8_duty", pwm_duty_cycle, 8'h02);
      chk("ramp_t8_busy", ramp_busy, 1'b1);
      repeat (4) tick();
      chk("ramp_t12_duty", pwm_duty_cycle, 8'h03);
      chk("ramp_t12_busy", ramp_busy, 1'b0);
      spi_write(7'h04, 8'hFF);
      repeat (20) tick();
      chk("ramp_up_mid", pwm_duty_cycle, 8'h08);
      spi_write(7'h04, 8'h00);
      chk("retarget_hold", pwm_duty_cycle, 8'h08);
      repeat (4) tick();
      chk("retarget_down", pwm_duty_cycle, 8'h07);
      chk("retarget_busy", ramp_busy, 1'b1);
`else
      spi_write(7'h04, 8'h80);
      chk("direct_duty", pwm_duty_cycle, 8'h80);
      chk("direct_busy", ramp_busy, 1'b0);
`endif

      // Reset while a local request is pending behind SPI
      spi_wr_valid = 1'b1; spi_wr_addr = 7'h09;
      loc_req = 1'b1; loc_addr = 7'h02; loc_data = 8'h77;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; spi_wr_valid = 1'b0; loc_req = 1'b0;
      chk("rst_regs", {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8}, 32'h0);
      chk("rst_duty_lock", {pwm_duty_cycle, 3'b000, lock_mask}, 16'h0);
      chk("rst_pulses", {loc_gnt, loc_err, ramp_busy}, 3'b000);
      tick();
      chk("rst_no_late_gnt", {loc_gnt, loc_err}, 2'b00);
      chk("rst_discarded", en_reg_pwm_7_0, 8'h00);
      $display("RST  mid-request reset");

      // Randomized traffic; the compare process checks every cycle
      hold = 0;
      req_done = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(0, 299) == 0) begin
            rst_n = 1'b0; spi_wr_valid = 1'b0; loc_req = 1'b0;
            hold = 0; req_done = 1'b0;
         end else begin
            rst_n = 1'b1;
            spi_wr_valid = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 15);
            spi_wr_addr = (r < 10) ? 7'(r % 5) : ((r < 12) ? 7'h07 : 7'($urandom_range(5, 127)));
            spi_wr_data = 8'($urandom);
            if (!loc_req || req_done) begin
               req_done = 1'b0;
               hold = 0;
               if ($urandom_range(0, 2) != 0) begin
                  r = $urandom_range(0, 15);
                  loc_req  = 1'b1;
                  loc_addr = (r < 12) ? 7'(r % 5) : ((r < 14) ? 7'h07 : 7'($urandom_range(5, 127)));
                  loc_data = 8'($urandom);
               end else begin
                  loc_req = 1'b0;
               end
            end
         end
         tick();
         if (loc_req) begin
            hold++;
            if (loc_gnt || loc_err) begin
               req_done = 1'b1;
               $display("RND  local addr=0x%02h data=0x%02h gnt=%0b err=%0b wait=%0d",
                        loc_addr, loc_data, loc_gnt, loc_err, hold);
            end else if (hold > 40) begin
               checks++;
               errors++;
               $display("FAIL loc_stall cycle=%0d got=no gnt/err after %0d cycles expected=response", cyc, hold);
               loc_req = 1'b0;
               hold = 0;
            end
         end
      end

      rst_n = 1'b1; spi_wr_valid = 1'b0; loc_req = 1'b0;
      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
